// File: rtl/clkgen_pkg.sv
// Shared limits and helpers for the integer clock divider.
// Optional sync_pulse output is enabled with CLKGEN_SYNC_PULSE_EN.
package clkgen_pkg;

  localparam int unsigned MIN_DIV_FACTOR = 2;
  localparam int unsigned MAX_DIV_FACTOR = 65536;

  // Counter width for a divide ratio n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clock_divider_stage.sv
// Single divide-by-DIV_FACTOR stage: wrapping counter plus a registered output.
// Under CLKGEN_SYNC_PULSE_EN it also exports wrap_next (counter returns to 0 on the next edge).
module clock_divider_stage #(
  parameter int unsigned DIV_FACTOR = 2
) (
  input  logic clk_in,
  input  logic reset,
`ifdef CLKGEN_SYNC_PULSE_EN
  output logic wrap_next,
`endif
  output logic clk_out
);
  import clkgen_pkg::*;

  localparam int unsigned W    = cnt_width(DIV_FACTOR);
  localparam logic [W-1:0] LAST = W'(DIV_FACTOR - 1);
  localparam logic [W-1:0] HALF = W'(DIV_FACTOR / 2);

  if (DIV_FACTOR < MIN_DIV_FACTOR || DIV_FACTOR > MAX_DIV_FACTOR) begin : g_bad_factor
    $error("clock_divider_stage: DIV_FACTOR %0d outside [%0d,%0d]",
           DIV_FACTOR, MIN_DIV_FACTOR, MAX_DIV_FACTOR);
  end

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt == LAST) ? '0 : cnt + W'(1);
  end

  // Output decided from cnt_next so it lands in a flop the same edge the counter moves.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      clk_out <= (cnt_next >= HALF);
    end
  end

`ifdef CLKGEN_SYNC_PULSE_EN
  assign wrap_next = (cnt == LAST);
`endif

endmodule

// File: rtl/clock_frequency_generator.sv
// Three independent integer clock dividers from one source clock.
// Define CLKGEN_SYNC_PULSE_EN to add sync_pulse, high one cycle when all counters realign at 0.
module clock_frequency_generator #(
  parameter int unsigned DIV_FACTOR_1 = 2,
  parameter int unsigned DIV_FACTOR_2 = 4,
  parameter int unsigned DIV_FACTOR_3 = 8
) (
  input  logic clk_in,
  input  logic reset,
  output logic clk_out_1,
  output logic clk_out_2,
  output logic clk_out_4
`ifdef CLKGEN_SYNC_PULSE_EN
  ,
  output logic sync_pulse
`endif
);
  import clkgen_pkg::*;

  localparam int NUM_STAGES = 3;
  localparam int unsigned DIVS [NUM_STAGES] = '{DIV_FACTOR_1, DIV_FACTOR_2, DIV_FACTOR_3};

  logic [NUM_STAGES-1:0] div_clk;
`ifdef CLKGEN_SYNC_PULSE_EN
  logic [NUM_STAGES-1:0] div_wrap;
`endif

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    clock_divider_stage #(
      .DIV_FACTOR(DIVS[g])
    ) u_stage (
      .clk_in   (clk_in),
      .reset    (reset),
`ifdef CLKGEN_SYNC_PULSE_EN
      .wrap_next(div_wrap[g]),
`endif
      .clk_out  (div_clk[g])
    );
  end

  assign clk_out_1 = div_clk[0];
  assign clk_out_2 = div_clk[1];
  assign clk_out_4 = div_clk[2];

`ifdef CLKGEN_SYNC_PULSE_EN
  // All counters wrap together on this edge -> every cnt is 0 right after it.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) sync_pulse <= 1'b0;
    else        sync_pulse <= &div_wrap;
  end
`endif

endmodule

// File: tb/tb_clock_frequency_generator.sv
// Directed bench for clock_frequency_generator: timing, async reset, duty/period, optional sync_pulse.
module tb_clock_frequency_generator;

  logic clk_in;
  logic reset;
  logic a1, a2, a4, b1, b2, b4, c1, c2, c4;
`ifdef CLKGEN_SYNC_PULSE_EN
  logic sa, sb, sc;
`endif

  int n_chk = 0;
  int n_err = 0;

  clock_frequency_generator #(.DIV_FACTOR_1(2), .DIV_FACTOR_2(4), .DIV_FACTOR_3(8)) dut_a (
    .clk_in(clk_in), .reset(reset), .clk_out_1(a1), .clk_out_2(a2), .clk_out_4(a4)
`ifdef CLKGEN_SYNC_PULSE_EN
    , .sync_pulse(sa)
`endif
  );

  clock_frequency_generator #(.DIV_FACTOR_1(5), .DIV_FACTOR_2(6), .DIV_FACTOR_3(7)) dut_b (
    .clk_in(clk_in), .reset(reset), .clk_out_1(b1), .clk_out_2(b2), .clk_out_4(b4)
`ifdef CLKGEN_SYNC_PULSE_EN
    , .sync_pulse(sb)
`endif
  );

  clock_frequency_generator #(.DIV_FACTOR_1(3), .DIV_FACTOR_2(4), .DIV_FACTOR_3(8)) dut_c (
    .clk_in(clk_in), .reset(reset), .clk_out_1(c1), .clk_out_2(c2), .clk_out_4(c4)
`ifdef CLKGEN_SYNC_PULSE_EN
    , .sync_pulse(sc)
`endif
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic at(input int t);
    #(t - int'($time));
  endtask

  // Observed outputs and their divide ratios for duty/period measurement.
  int fac [7] = '{2, 4, 8, 5, 6, 7, 3};
  int first_rise [7];
  int last_rise [7];
  int period [7];
  int high_len [7];
  logic [6:0] obs, prev;

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      first_rise[i] = 0; last_rise[i] = 0; period[i] = 0; high_len[i] = 0;
    end
    prev = '0;

    at(2);
    chk("reset_a", {29'd0, a4, a2, a1}, 32'b000);
    chk("reset_bc", {26'd0, c4, c2, c1, b4, b2, b1}, 32'd0);
    at(20); reset = 1'b1;
    at(22);  chk("pre_edge1", {29'd0, a4, a2, a1}, 32'b000);
    at(26);  chk("edge1",     {29'd0, a4, a2, a1}, 32'b001);
    at(36);  chk("edge2",     {29'd0, a4, a2, a1}, 32'b010);
    at(46);  chk("edge3",     {29'd0, a4, a2, a1}, 32'b011);
    at(56);  chk("edge4",     {29'd0, a4, a2, a1}, 32'b100);
    at(86);  chk("edge7",     {29'd0, a4, a2, a1}, 32'b111);
    at(96);  chk("edge8",     {29'd0, a4, a2, a1}, 32'b000);

    at(102); reset = 1'b0;
    at(103); chk("mid_rst_now", {26'd0, c4, c2, c1, b4, b2, b1}, 32'd0);
    at(106); chk("mid_rst_hold", {29'd0, a4, a2, a1}, 32'b000);
`ifdef CLKGEN_SYNC_PULSE_EN
    chk("sync_in_reset", {31'd0, sa}, 32'd0);
`endif
    at(116); chk("mid_rst_hold2", {26'd0, c4, c2, c1, b4, b2, b1}, 32'd0);
    at(120); reset = 1'b1;

    // Edge e after release occurs at 115 + 10*e; sample 1ns later.
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk_in); #1;
      obs = {c1, b4, b2, b1, a4, a2, a1};
      if (e == 1) chk("rerun_e1", {29'd0, a4, a2, a1}, 32'b001);
      if (e == 2) chk("rerun_e2", {29'd0, a4, a2, a1}, 32'b010);
      if (e == 3) chk("rerun_e3", {29'd0, a4, a2, a1}, 32'b011);
      if (e == 4) chk("rerun_e4", {29'd0, a4, a2, a1}, 32'b100);
`ifdef CLKGEN_SYNC_PULSE_EN
      chk($sformatf("sync_a_e%0d", e), {31'd0, sa}, {31'd0, (e % 8) == 0});
      chk($sformatf("sync_b_e%0d", e), {31'd0, sb}, 32'd0);
`endif
      for (int i = 0; i < 7; i++) begin
        if (obs[i] && !prev[i]) begin
          if (first_rise[i] == 0) first_rise[i] = e;
          else period[i] = e - last_rise[i];
          last_rise[i] = e;
        end
        if (!obs[i] && prev[i]) high_len[i] = e - last_rise[i];
      end
      prev = obs;
    end

    for (int i = 0; i < 7; i++) begin
      chk($sformatf("first_rise[N=%0d]", fac[i]), first_rise[i], fac[i] / 2);
      chk($sformatf("period_ns[N=%0d]", fac[i]), period[i] * 10, fac[i] * 10);
      chk($sformatf("high_ns[N=%0d]", fac[i]), high_len[i] * 10, ((fac[i] + 1) / 2) * 10);
    end

    // Now at 1116, after edge 100: dut_a cnt4=4 on the /8 stage, dut_b /6 stage at 4.
    chk("e100_a", {29'd0, a4, a2, a1}, 32'b100);
    chk("e100_b", {29'd0, b4, b2, b1}, 32'b010);
    #2 reset = 1'b0;
    #1 chk("async_rst_a", {29'd0, a4, a2, a1}, 32'b000);
    chk("async_rst_b", {29'd0, b4, b2, b1}, 32'b000);
    #3 reset = 1'b1;
    @(posedge clk_in); #1;
    chk("realign_a", {29'd0, a4, a2, a1}, 32'b001);
    chk("realign_b", {29'd0, b4, b2, b1}, 32'b000);
    chk("realign_c", {29'd0, c4, c2, c1}, 32'b001);
`ifdef CLKGEN_SYNC_PULSE_EN
    chk("sync_first_cycle", {31'd0, sa}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
